// File: rtl/app_frac_mc_pkg.sv
// app_frac_pkg: register offsets and shared constants for the ring-fracture detector.
package app_frac_pkg;
   localparam int NCH_MAX = 32;
   localparam logic [5:0] FIRST_NONE = 6'h3F;
   localparam logic [7:0] OFF_ID = 8'h00;
   localparam logic [7:0] OFF_TH_LO = 8'h01;
   localparam logic [7:0] OFF_TH_HI = 8'h02;
   localparam logic [7:0] OFF_HOLD = 8'h03;
   localparam logic [7:0] OFF_FIRST = 8'h04;
   localparam logic [7:0] OFF_STU = 8'h10;
   localparam logic [7:0] OFF_MASK = 8'h14;
   localparam logic [7:0] OFF_CLR = 8'h20;
   localparam logic [7:0] OFF_CNT = 8'h40;
   function automatic logic [5:0] lowest(input logic [31:0] v);
      logic [5:0] r;
      r = FIRST_NONE;
      for (int i = 31; i >= 0; i--) if (v[i]) r = 6'(i);
      return r;
   endfunction
endpackage

// File: rtl/app_frac_mc_if.sv
// app_frac_mc_if: fx register bus plus interrupt line between host and detector.
interface app_frac_mc_if;
   logic fx_wr;
   logic [21:0] fx_waddr;
   logic [7:0] fx_data;
   logic fx_rd;
   logic [21:0] fx_raddr;
   logic [7:0] fx_q;
   logic irq_n;
   modport master(output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, input fx_q, irq_n);
   modport slave(input fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, output fx_q, irq_n);
endinterface

// File: rtl/app_frac_mc_chan.sv
// frac_chan: per-channel over-threshold run counter, qualify pulse and saturating event count.
module frac_chan #(
   parameter int CNTW = 8
) (
   input  logic            clk_sys,
   input  logic            rst,
   input  logic            vld,
   input  logic [15:0]     smp,
   input  logic [15:0]     th,
   input  logic [7:0]      hold,
   input  logic            clr,
   output logic            evt,
   output logic [CNTW-1:0] evt_cnt
);
   logic [7:0] run_q, run_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic over;
   always_comb begin
      over = smp > th;
      run_d = !vld ? run_q : !over ? 8'd0 : run_q == 8'hFF ? run_q : run_q + 8'd1;
      // fire only on the transition into the hold value, so a long run fires once
      evt = vld && over && run_d == hold && run_q != hold;
      cnt_d = clr ? '0 : (evt && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         run_q <= '0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end
   assign evt_cnt = cnt_q;
endmodule

// File: rtl/app_frac_mc.sv
// app_frac_mc: multi-channel ring-fracture detector with fx-bus register file and masked irq.
module app_frac_mc
   import app_frac_pkg::*;
#(
   parameter int NCH  = 8,
   parameter int DW   = 16,
   parameter int CNTW = 8
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic [5:0]        dev_id,
   input  logic [NCH*DW-1:0] ph_ring,
   input  logic [NCH-1:0]    ph_vld,
   app_frac_mc_if.slave      fx
);
   localparam logic [31:0] CH_MSK = 32'((64'd1 << NCH) - 64'd1);
   logic [15:0] th_q, th_d;
   logic [7:0] hold_q, hold_d, hold_eff, rd_q, rd_d, rv, woff, roff;
   logic [31:0] stu_q, stu_d, mask_q, mask_d, w1c, evt;
   logic [5:0] first_q, first_d;
   logic irqn_q, irqn_d, wr_hit, rd_hit, clr, unused_ok;
   logic [CNTW-1:0] cnt [NCH_MAX];
   for (genvar c = 0; c < NCH_MAX; c++) begin : g_ch
      if (c < NCH) begin : g_on
         frac_chan #(.CNTW(CNTW)) u_chan (
            .clk_sys(clk_sys), .rst(rst), .vld(ph_vld[c]), .smp(16'(ph_ring[c*DW +: DW])),
            .th(th_q), .hold(hold_eff), .clr(clr), .evt(evt[c]), .evt_cnt(cnt[c])
         );
      end else begin : g_off
         assign evt[c] = 1'b0;
         assign cnt[c] = '0;
      end
   end
   assign unused_ok = ^{fx.fx_waddr[15:8], fx.fx_raddr[15:8]};
   always_comb begin
      woff = fx.fx_waddr[7:0];
      roff = fx.fx_raddr[7:0];
      wr_hit = fx.fx_wr && fx.fx_waddr[21:16] == dev_id;
      rd_hit = fx.fx_raddr[21:16] == dev_id;
      clr = wr_hit && woff == OFF_CLR;
      hold_eff = hold_q == 8'd0 ? 8'd1 : hold_q;
      th_d = th_q;
      if (wr_hit && woff == OFF_TH_LO) th_d[7:0] = fx.fx_data;
      if (wr_hit && woff == OFF_TH_HI) th_d[15:8] = fx.fx_data;
      hold_d = (wr_hit && woff == OFF_HOLD) ? fx.fx_data : hold_q;
      w1c = (wr_hit && woff[7:2] == OFF_STU[7:2]) ? 32'(fx.fx_data) << {woff[1:0], 3'b000} : '0;
      // a new event in the same cycle as its W1C keeps the bit set
      stu_d = ((stu_q & ~w1c) | evt) & CH_MSK;
      mask_d = mask_q;
      if (wr_hit && woff[7:2] == OFF_MASK[7:2]) mask_d[{woff[1:0], 3'b000} +: 8] = fx.fx_data;
      mask_d = mask_d & CH_MSK;
      first_d = stu_d == '0 ? FIRST_NONE : stu_q == '0 ? lowest(evt) : first_q;
      irqn_d = ~|(stu_q & mask_q);
      rv = 8'h00;
      if (roff == OFF_ID) rv = {2'b00, dev_id};
      else if (roff == OFF_TH_LO) rv = th_q[7:0];
      else if (roff == OFF_TH_HI) rv = th_q[15:8];
      else if (roff == OFF_HOLD) rv = hold_q;
      else if (roff == OFF_FIRST) rv = {2'b00, first_q};
      else if (roff[7:2] == OFF_STU[7:2]) rv = stu_q[{roff[1:0], 3'b000} +: 8];
      else if (roff[7:2] == OFF_MASK[7:2]) rv = mask_q[{roff[1:0], 3'b000} +: 8];
      else if (roff[7:5] == OFF_CNT[7:5]) rv = 8'(cnt[roff[4:0]]);
      rd_d = !fx.fx_rd ? rd_q : rd_hit ? rv : 8'h00;
   end
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         th_q <= '0;
         hold_q <= 8'd1;
         stu_q <= '0;
         mask_q <= '0;
         first_q <= FIRST_NONE;
         irqn_q <= 1'b1;
         rd_q <= '0;
      end else begin
         th_q <= th_d;
         hold_q <= hold_d;
         stu_q <= stu_d;
         mask_q <= mask_d;
         first_q <= first_d;
         irqn_q <= irqn_d;
         rd_q <= rd_d;
      end
   end
   assign fx.fx_q = rd_q;
   assign fx.irq_n = irqn_q;
endmodule

// File: tb/tb_app_frac_mc.sv
// tb_app_frac_mc: directed vectors with hand-computed expectations for app_frac_mc.
module tb_app_frac_mc;
   logic clk_sys = 1'b0;
   logic rst = 1'b1;
   logic [5:0] dev_id = 6'h15;
   logic [127:0] ph_ring = '0;
   logic [7:0] ph_vld = '0;
   int n = 0;
   int err = 0;
   app_frac_mc_if fx();
   app_frac_mc #(.NCH(8), .DW(16), .CNTW(8)) dut (
      .clk_sys(clk_sys), .rst(rst), .dev_id(dev_id), .ph_ring(ph_ring), .ph_vld(ph_vld), .fx(fx)
   );
   always #5 clk_sys = ~clk_sys;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wrp(input logic [5:0] pg, input logic [7:0] off, input logic [7:0] d);
      fx.fx_wr = 1'b1;
      fx.fx_waddr = {pg, 8'h00, off};
      fx.fx_data = d;
      @(negedge clk_sys);
      fx.fx_wr = 1'b0;
   endtask
   task automatic wr(input logic [7:0] off, input logic [7:0] d);
      wrp(dev_id, off, d);
   endtask
   task automatic rdp(input logic [5:0] pg, input logic [7:0] off, input logic [7:0] exp, input string tag);
      fx.fx_rd = 1'b1;
      fx.fx_raddr = {pg, 8'h00, off};
      @(negedge clk_sys);
      fx.fx_rd = 1'b0;
      chk(tag, fx.fx_q, exp);
   endtask
   task automatic rd(input logic [7:0] off, input logic [7:0] exp, input string tag);
      rdp(dev_id, off, exp, tag);
   endtask
   task automatic smp(input int c, input logic [15:0] v);
      ph_ring[c*16 +: 16] = v;
      ph_vld[c] = 1'b1;
      @(negedge clk_sys);
      ph_vld = '0;
   endtask
   initial begin
      fx.fx_wr = 1'b0;
      fx.fx_rd = 1'b0;
      fx.fx_waddr = '0;
      fx.fx_raddr = '0;
      fx.fx_data = '0;
      repeat (2) @(negedge clk_sys);
      chk("irq_rst", {7'b0, fx.irq_n}, 8'h01);
      chk("fxq_rst", fx.fx_q, 8'h00);
      rst = 1'b0;
      rd(8'h00, 8'h15, "dev_id");
      rd(8'h03, 8'h01, "hold_rst");
      rd(8'h04, 8'h3F, "first_rst");
      rd(8'h01, 8'h00, "th_rst");
      rd(8'h10, 8'h00, "stu_rst");
      // 1: basic qualify on ch2
      wr(8'h01, 8'd100);
      wr(8'h02, 8'd0);
      wr(8'h03, 8'd3);
      wr(8'h14, 8'hFF);
      smp(2, 16'd101);
      smp(2, 16'd150);
      rd(8'h10, 8'h00, "stu_pre");
      smp(2, 16'd200);
      rd(8'h10, 8'h04, "stu_ch2");
      rd(8'h42, 8'h01, "cnt_ch2");
      rd(8'h04, 8'h02, "first_ch2");
      chk("irq_ch2", {7'b0, fx.irq_n}, 8'h00);
      @(negedge clk_sys);
      chk("fxq_hold", fx.fx_q, 8'h02);
      wr(8'h10, 8'h04);
      rd(8'h04, 8'h3F, "first_clr");
      // 2: broken run, then exactly one event per run of 10
      smp(0, 16'd101);
      smp(0, 16'd50);
      smp(0, 16'd101);
      smp(0, 16'd101);
      rd(8'h40, 8'h00, "cnt_ch0_none");
      for (int i = 0; i < 8; i++) smp(0, 16'd101);
      rd(8'h40, 8'h01, "cnt_ch0_once");
      smp(0, 16'd0);
      wr(8'h10, 8'h01);
      // 3: simultaneous fire, lowest index wins first_ch
      for (int i = 0; i < 3; i++) begin
         ph_ring[5*16 +: 16] = 16'd101;
         ph_ring[1*16 +: 16] = 16'd101;
         ph_vld = 8'h22;
         @(negedge clk_sys);
         ph_vld = '0;
      end
      rd(8'h10, 8'h22, "stu_multi");
      rd(8'h04, 8'h01, "first_multi");
      wr(8'h10, 8'h02);
      rd(8'h10, 8'h20, "stu_w1c1");
      rd(8'h04, 8'h01, "first_keep");
      wr(8'h10, 8'h20);
      rd(8'h10, 8'h00, "stu_w1c5");
      rd(8'h04, 8'h3F, "first_none");
      chk("irq_clear", {7'b0, fx.irq_n}, 8'h01);
      // 4: masking and W1C-vs-set race
      wr(8'h14, 8'h00);
      for (int i = 0; i < 3; i++) smp(3, 16'd101);
      rd(8'h10, 8'h08, "stu_ch3");
      chk("irq_masked", {7'b0, fx.irq_n}, 8'h01);
      wr(8'h14, 8'h08);
      chk("irq_lat", {7'b0, fx.irq_n}, 8'h01);
      @(negedge clk_sys);
      chk("irq_unmask", {7'b0, fx.irq_n}, 8'h00);
      smp(3, 16'd0);
      smp(3, 16'd101);
      smp(3, 16'd101);
      ph_ring[3*16 +: 16] = 16'd101;
      ph_vld[3] = 1'b1;
      fx.fx_wr = 1'b1;
      fx.fx_waddr = {dev_id, 8'h00, 8'h10};
      fx.fx_data = 8'h08;
      @(negedge clk_sys);
      ph_vld = '0;
      fx.fx_wr = 1'b0;
      rd(8'h10, 8'h08, "set_wins");
      rd(8'h43, 8'h02, "cnt_ch3");
      wr(8'h10, 8'h08);
      // 5: hold 0 acts as 1; counter saturation and clear-vs-event race
      wr(8'h03, 8'd0);
      rd(8'h03, 8'h00, "hold_raw0");
      smp(7, 16'd101);
      rd(8'h47, 8'h01, "cnt_hold0");
      for (int i = 0; i < 299; i++) begin
         smp(7, 16'd0);
         smp(7, 16'd101);
      end
      rd(8'h47, 8'hFF, "cnt_sat");
      smp(7, 16'd0);
      ph_ring[7*16 +: 16] = 16'd101;
      ph_vld[7] = 1'b1;
      fx.fx_wr = 1'b1;
      fx.fx_waddr = {dev_id, 8'h00, 8'h20};
      fx.fx_data = 8'h5A;
      @(negedge clk_sys);
      ph_vld = '0;
      fx.fx_wr = 1'b0;
      rd(8'h47, 8'h00, "clr_wins");
      rd(8'h40, 8'h00, "clr_all");
      // 6: page miss, out-of-range bytes, reset mid-run
      wr(8'h03, 8'd5);
      wrp(6'h2A, 8'h01, 8'h55);
      rd(8'h01, 8'h64, "th_keep");
      rdp(6'h2A, 8'h00, 8'h00, "page_miss");
      wr(8'h17, 8'hFF);
      rd(8'h17, 8'h00, "mask_hi");
      wr(8'h14, 8'hFF);
      smp(4, 16'd101);
      smp(4, 16'd101);
      chk("irq_pre_rst", {7'b0, fx.irq_n}, 8'h00);
      rst = 1'b1;
      ph_ring[4*16 +: 16] = 16'd101;
      ph_vld[4] = 1'b1;
      @(negedge clk_sys);
      ph_vld = '0;
      rst = 1'b0;
      chk("irq_post_rst", {7'b0, fx.irq_n}, 8'h01);
      rd(8'h10, 8'h00, "stu_post_rst");
      rd(8'h03, 8'h01, "hold_post_rst");
      rd(8'h04, 8'h3F, "first_post_rst");
      rd(8'h44, 8'h00, "cnt_post_rst");
      $display("== %0d vectors applied, %0d miscompares ==", n, err);
      $finish;
   end
endmodule
